// File: rtl/sram_dp_be_if.sv
// sram_dp_be_if: dual-port SRAM bus; master drives write/read/clear requests, slave returns rdata/rvalid/busy
interface sram_dp_be_if #(
  parameter int WIDTH  = 32,
  parameter int LENGTH = 256,
  parameter int ADDR_W = $clog2(LENGTH)
);
  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic [WIDTH-1:0]  wdata;
  logic [WIDTH/8-1:0] wbe;
  logic              re;
  logic [ADDR_W-1:0] raddr;
  logic [WIDTH-1:0]  rdata;
  logic              rvalid;
  logic              clear_req;
  logic              busy;
  modport master(output we, waddr, wdata, wbe, re, raddr, clear_req, input rdata, rvalid, busy);
  modport slave(input we, waddr, wdata, wbe, re, raddr, clear_req, output rdata, rvalid, busy);
endinterface

// File: rtl/sram_dp_be.sv
// sram_dp_be: simple-dual-port SRAM with byte-enable write, registered write-first read, clear engine; ports clk, rst_n, bus (sram_dp_be_if.slave)
module sram_dp_be #(
  parameter int WIDTH  = 32,
  parameter int LENGTH = 256,
  localparam int ADDR_W = $clog2(LENGTH)
) (
  input logic clk,
  input logic rst_n,
  sram_dp_be_if.slave bus
);
  typedef enum logic {CLEAR, IDLE} state_t;
  localparam logic [ADDR_W:0] len = (ADDR_W+1)'(LENGTH);
  localparam logic [ADDR_W-1:0] last = ADDR_W'(LENGTH-1);
  state_t state, state_nxt;
  logic [ADDR_W-1:0] ptr, ptr_nxt;
  logic [WIDTH-1:0] mem [LENGTH];
  logic [WIDTH-1:0] rd_word, rdata;
  logic rvalid, wr_ok, rd_in, rd_ok;
  assign bus.busy = state == CLEAR;
  assign bus.rdata = rdata;
  assign bus.rvalid = rvalid;
  assign wr_ok = state == IDLE && bus.we && {1'b0, bus.waddr} < len;
  assign rd_in = {1'b0, bus.raddr} < len;
  assign rd_ok = state == IDLE && bus.re;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= CLEAR;
      ptr <= '0;
    end else begin
      state <= state_nxt;
      ptr <= ptr_nxt;
    end
  always_comb begin
    state_nxt = state == CLEAR ? (ptr == last ? IDLE : CLEAR) : (bus.clear_req ? CLEAR : IDLE);
    ptr_nxt = (state == CLEAR && ptr != last) ? ptr + 1'b1 : '0;
  end
  always_ff @(posedge clk)
    if (state == CLEAR) mem[ptr] <= '0;
    else if (wr_ok)
      for (int k = 0; k < WIDTH/8; k++)
        if (bus.wbe[k]) mem[bus.waddr][8*k +: 8] <= bus.wdata[8*k +: 8];
  always_comb begin
    rd_word = rd_in ? mem[bus.raddr] : '0;
    for (int k = 0; k < WIDTH/8; k++)
      if (wr_ok && bus.wbe[k] && bus.waddr == bus.raddr) rd_word[8*k +: 8] = bus.wdata[8*k +: 8];
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      rdata <= '0;
      rvalid <= 1'b0;
    end else begin
      rvalid <= rd_ok;
      if (rd_ok) rdata <= rd_word;
    end
endmodule

// File: doc/sram_dp_be.md
Name: sram_dp_be

Overview:
Parametrised simple-dual-port synchronous SRAM, the successor to the single-port word RAM. It has one write port with byte enables and an independent read port with registered data and a valid strobe. A built-in clear engine zeroes the whole array after reset and on request. It serves as the CPU data/scratch memory, where the core needs one write and one read per cycle.

Parameters:
WIDTH, 32, data word width in bits; must be a multiple of 8
LENGTH, 256, number of words; need not be a power of two
ADDR_W, $clog2(LENGTH), address width (derived; do not override)

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
we  input  1  write enable
waddr  input  ADDR_W  write address
wdata  input  WIDTH  write data
wbe  input  WIDTH/8  byte enables; bit k selects wdata[8k+7:8k]
re  input  1  read enable
raddr  input  ADDR_W  read address
rdata  output  WIDTH  registered read data
rvalid  output  1  rdata valid strobe, one pulse per accepted read
clear_req  input  1  request a full-array clear
busy  output  1  clear engine active; port accesses ignored

Behaviour:
- Reset: one clock (clk); rst_n is asynchronous and active-low. While rst_n=0: rdata=0, rvalid=0, busy=1, FSM=CLEAR, clear pointer=0. The memory array is not reset.
- FSM states:
  - CLEAR: each cycle writes 0 to the word at the pointer, then pointer+1. After writing word LENGTH-1, go to IDLE.
  - IDLE: normal operation. clear_req=1 sampled on a clk edge moves to CLEAR with pointer=0.
- busy=1 in CLEAR. After rst_n rises, busy stays high for exactly LENGTH rising edges and reads 0 from the following cycle.
- clear_req while busy is ignored (no restart, no queueing).
- rst_n asserted mid-clear aborts the clear. After release, the clear restarts from address 0.
- While busy=1: we and re are ignored, rvalid=0, rdata holds its value.
- Write (IDLE, we=1, waddr<LENGTH): on the clk edge, update only the byte lanes with wbe[k]=1; other lanes keep their old value. wbe=0 is a no-op.
- Read (IDLE, re=1): rdata and rvalid are valid 1 cycle after the sampling edge. rvalid=1 for exactly one cycle per accepted read. With re=0, rvalid=0 on the next cycle and rdata holds its last value.
- Back-to-back reads sustain one per cycle.
- Read-during-write, same address, same edge (write-first): rdata returns the old word with enabled lanes replaced by wdata, i.e. the new contents.
- Read-during-write, different addresses: the two operations are fully independent.
- Out-of-range address (>=LENGTH, possible when LENGTH is not a power of two):
  - write is dropped;
  - read returns rdata=0 with rvalid=1.
- clear_req and we/re on the same edge in IDLE: that write and read are still performed. The CLEAR state begins on the next cycle and later zeroes the written word.

Test Plan:
- Reset, then release rst_n with default params: busy=1 for 256 edges then 0. Afterwards, reading addr 0, 100 and 255 gives rdata=0x00000000 with rvalid=1 one cycle after re.
- Write 0xDEADBEEF to addr 5 with wbe=4'b1111, then write 0x11223344 to addr 5 with wbe=4'b0101. Reading addr 5 returns 0xDE22BE44.
- Walking-ones sweep: for i=0..255 write a word with bits i%32 and 31-i%32 set, then read all 256 back-to-back. Each rdata matches, and rvalid stays high for 256 consecutive cycles.
- Same-edge write 0xCAFEF00D to addr 7 (wbe=4'b0011) with read of addr 7 holding 0xAAAAAAAA: rdata=0xAAAAF00D the next cycle.
- Fill addr 9 with 0x12345678, pulse clear_req, and issue we/re during busy:
  - busy=1 for 256 cycles and rvalid stays 0;
  - the write issued during busy is not stored;
  - after busy falls, addr 9 reads 0.
  Assert rst_n=0 at clear pointer 100: after release, busy again lasts 256 cycles.
- LENGTH=200, ADDR_W=8:
  - write to addr 210 is dropped;
  - read of addr 210 gives rdata=0 with rvalid=1;
  - addr 199 round-trips 0x0F0F0F0F;
  - the post-reset clear lasts 200 cycles.
